// File: rtl/operand_stack.sv
// LIFO operand stack controller: turns push/pop/peek/clear commands into
// single-port data-memory cycles and absorbs the memory's registered read latency.
module operand_stack #(
    parameter int                DATA_W = 16,
    parameter int                ADDR_W = 16,
    parameter logic [ADDR_W-1:0] BASE   = '0,
    parameter int                DEPTH  = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [1:0]        cmd_op,
    input  logic [DATA_W-1:0] cmd_data,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_data,
    output logic              rsp_err,
    output logic [15:0]       count,
    output logic              full,
    output logic              empty,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_din,
    input  logic [DATA_W-1:0] mem_dout,
    output logic [1:0]        dbg_state
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WR   = 2'd1,
        RD   = 2'd2,
        CAP  = 2'd3
    } state_e;

    localparam logic [1:0]  OP_PUSH  = 2'd0;
    localparam logic [1:0]  OP_POP   = 2'd1;
    localparam logic [1:0]  OP_PEEK  = 2'd2;
    localparam logic [1:0]  OP_CLEAR = 2'd3;
    localparam logic [15:0] DEPTH_C  = 16'(DEPTH);

    // Handshake: a command transfers on any rising edge where cmd_valid and
    // cmd_ready are both high; cmd_ready is high exactly while the FSM is idle.

    state_e              state_q, state_d;
    logic [15:0]         count_q, count_d;
    logic                mem_we_q, mem_we_d;
    logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0]   mem_din_q, mem_din_d;
    logic                rsp_valid_q, rsp_valid_d;
    logic [DATA_W-1:0]   rsp_data_q, rsp_data_d;
    logic                rsp_err_q, rsp_err_d;
    logic                pop_q, pop_d;
    logic                full_w, empty_w;

    assign full_w  = (count_q == DEPTH_C);
    assign empty_w = (count_q == 16'd0);

    always_comb begin
        state_d     = state_q;
        count_d     = count_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_din_d   = mem_din_q;
        rsp_valid_d = 1'b0;
        rsp_data_d  = rsp_data_q;
        rsp_err_d   = rsp_err_q;
        pop_d       = pop_q;
        case (state_q)
            IDLE: begin
                if (cmd_valid) begin
                    case (cmd_op)
                        OP_PUSH: begin
                            if (full_w) begin
                                rsp_valid_d = 1'b1;
                                rsp_err_d   = 1'b1;
                                rsp_data_d  = '0;
                            end else begin
                                mem_addr_d = BASE + ADDR_W'(count_q);
                                mem_din_d  = cmd_data;
                                mem_we_d   = 1'b1;
                                state_d    = WR;
                            end
                        end
                        OP_POP, OP_PEEK: begin
                            if (empty_w) begin
                                rsp_valid_d = 1'b1;
                                rsp_err_d   = 1'b1;
                                rsp_data_d  = '0;
                            end else begin
                                mem_addr_d = BASE + ADDR_W'(count_q - 16'd1);
                                mem_we_d   = 1'b0;
                                pop_d      = (cmd_op == OP_POP);
                                state_d    = RD;
                            end
                        end
                        default: begin
                            count_d     = '0;
                            rsp_valid_d = 1'b1;
                            rsp_err_d   = 1'b0;
                        end
                    endcase
                end
            end
            WR: begin
                mem_we_d    = 1'b0;
                count_d     = count_q + 16'd1;
                rsp_valid_d = 1'b1;
                rsp_err_d   = 1'b0;
                state_d     = IDLE;
            end
            RD: begin
                // Registered memory: data appears one cycle after the address.
                state_d = CAP;
            end
            default: begin
                rsp_data_d  = mem_dout;
                rsp_valid_d = 1'b1;
                rsp_err_d   = 1'b0;
                if (pop_q) count_d = count_q - 16'd1;
                state_d     = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            count_q     <= '0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= BASE;
            mem_din_q   <= '0;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= '0;
            rsp_err_q   <= 1'b0;
            pop_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            count_q     <= count_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_din_q   <= mem_din_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
            rsp_err_q   <= rsp_err_d;
            pop_q       <= pop_d;
        end
    end

    // Gate the write strobe with reset so an in-flight write dies the moment reset lands.
    assign mem_we    = mem_we_q & rst_n;
    assign cmd_ready = (state_q == IDLE);
    assign rsp_valid = rsp_valid_q;
    assign rsp_data  = rsp_data_q;
    assign rsp_err   = rsp_err_q;
    assign count     = count_q;
    assign full      = full_w;
    assign empty     = empty_w;
    assign mem_addr  = mem_addr_q;
    assign mem_din   = mem_din_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_operand_stack.sv
// Bench for operand_stack: queue-based reference stack, registered memory model,
// and a negedge monitor that scores every response against an expected queue.
module tb_operand_stack;

  localparam int          DEPTH = 4;
  localparam logic [15:0] BASE  = 16'h0040;

  logic        clk;
  logic        rst_n;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [1:0]  cmd_op;
  logic [15:0] cmd_data;
  logic        rsp_valid;
  logic [15:0] rsp_data;
  logic        rsp_err;
  logic [15:0] count;
  logic        full;
  logic        empty;
  logic        mem_we;
  logic [15:0] mem_addr;
  logic [15:0] mem_din;
  logic [15:0] mem_dout;
  logic [1:0]  dbg_state;

  operand_stack #(
    .DATA_W(16), .ADDR_W(16), .BASE(BASE), .DEPTH(DEPTH)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op), .cmd_data(cmd_data),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_err(rsp_err),
    .count(count), .full(full), .empty(empty),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_din(mem_din), .mem_dout(mem_dout),
    .dbg_state(dbg_state)
  );

  // ---------------- clock / reset / memory model ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  int we_cnt = 0;
  always @(posedge clk) begin
    cyc = cyc + 1;
    if (mem_we) we_cnt = we_cnt + 1;
  end

  logic [15:0] mem [0:65535];
  always @(posedge clk) begin
    if (mem_we) mem[mem_addr] <= mem_din;
    mem_dout <= mem[mem_addr];
  end

  // ---------------- scoreboard ----------------
  typedef struct packed {
    logic [31:0] due;
    logic        err;
    logic [15:0] data;
    logic [15:0] cnt;
  } exp_t;

  exp_t        exp_q[$];
  logic [15:0] model_q[$];
  logic [15:0] last_data = 16'h0;
  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks = n_checks + 1;
    if (act !== req) begin
      n_fail = n_fail + 1;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, req, $time);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n && rsp_valid) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_rsp_valid", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("rsp_latency", 32'(cyc), e.due);
        chk("rsp_err", {31'd0, rsp_err}, {31'd0, e.err});
        chk("rsp_data", {16'd0, rsp_data}, {16'd0, e.data});
        chk("count", {16'd0, count}, {16'd0, e.cnt});
        chk("full", {31'd0, full}, {31'd0, (e.cnt == 16'(DEPTH))});
        chk("empty", {31'd0, empty}, {31'd0, (e.cnt == 16'd0)});
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic issue(input logic [1:0] op, input logic [15:0] data);
    int guard;
    int lat;
    exp_t e;
    @(negedge clk);
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_data  = data;
    guard = 0;
    while (!cmd_ready && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    if (!cmd_ready) begin
      chk("cmd_ready_timeout", 32'd0, 32'd1);
      cmd_valid = 1'b0;
      return;
    end
    e.err = 1'b0;
    case (op)
      2'd0: begin
        if (model_q.size() == DEPTH) begin
          e.err = 1'b1; last_data = 16'h0; lat = 1;
        end else begin
          model_q.push_back(data); lat = 2;
        end
      end
      2'd1, 2'd2: begin
        if (model_q.size() == 0) begin
          e.err = 1'b1; last_data = 16'h0; lat = 1;
        end else begin
          last_data = model_q[$];
          if (op == 2'd1) void'(model_q.pop_back());
          lat = 3;
        end
      end
      default: begin
        model_q.delete(); lat = 1;
      end
    endcase
    e.data = last_data;
    e.cnt  = 16'(model_q.size());
    e.due  = 32'(cyc + lat);
    exp_q.push_back(e);
    @(posedge clk);
    #1 cmd_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int guard = 0;
    while (exp_q.size() != 0 && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    if (exp_q.size() != 0) begin
      chk("response_timeout", 32'(exp_q.size()), 32'd0);
      exp_q.delete();
    end
    @(negedge clk);
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rst_n = 1'b0;
    cmd_valid = 1'b0;
    exp_q.delete();
    model_q.delete();
    last_data = 16'h0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic check_reset_values();
    chk("rst_cmd_ready", {31'd0, cmd_ready}, 32'd1);
    chk("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    chk("rst_rsp_data", {16'd0, rsp_data}, 32'd0);
    chk("rst_rsp_err", {31'd0, rsp_err}, 32'd0);
    chk("rst_count", {16'd0, count}, 32'd0);
    chk("rst_full", {31'd0, full}, 32'd0);
    chk("rst_empty", {31'd0, empty}, 32'd1);
    chk("rst_mem_we", {31'd0, mem_we}, 32'd0);
    chk("rst_mem_addr", {16'd0, mem_addr}, {16'd0, BASE});
    chk("rst_mem_din", {16'd0, mem_din}, 32'd0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int we_before;
    logic [15:0] prior;
    for (int i = 0; i < 65536; i++) mem[i] = 16'h5A5A;
    rst_n = 1'b0; cmd_valid = 1'b0; cmd_op = 2'd0; cmd_data = 16'h0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check_reset_values();

    // LIFO order
    issue(2'd0, 16'h1234);
    issue(2'd0, 16'hABCD);
    issue(2'd1, 16'h0);
    issue(2'd2, 16'h0);
    issue(2'd1, 16'h0);
    wait_idle();
    chk("lifo_empty", {31'd0, empty}, 32'd1);

    // Underflow never touches memory
    we_before = we_cnt;
    issue(2'd1, 16'h0);
    issue(2'd2, 16'h0);
    issue(2'd1, 16'h0);
    wait_idle();
    chk("underflow_no_we", 32'(we_cnt), 32'(we_before));
    chk("underflow_count", {16'd0, count}, 32'd0);

    // Overflow
    for (int i = 1; i <= 4; i++) issue(2'd0, 16'(i));
    wait_idle();
    chk("ovf_full", {31'd0, full}, 32'd1);
    mem[BASE + 16'd4] = 16'hC0DE;
    we_before = we_cnt;
    issue(2'd0, 16'd5);
    wait_idle();
    chk("ovf_no_we", 32'(we_cnt), 32'(we_before));
    chk("ovf_mem_untouched", {16'd0, mem[BASE + 16'd4]}, 32'h0000C0DE);
    for (int i = 0; i < 4; i++) issue(2'd1, 16'h0);
    wait_idle();

    // Clear with count=3, then pop underflows
    for (int i = 0; i < 3; i++) issue(2'd0, 16'(16'h0100 + i));
    issue(2'd3, 16'h0);
    issue(2'd1, 16'h0);
    wait_idle();
    chk("clear_empty", {31'd0, empty}, 32'd1);

    // Mid-stream reset with a pop in flight
    issue(2'd0, 16'h7777);
    issue(2'd1, 16'h0);
    apply_reset();
    check_reset_values();

    // Reset during WR
    prior = mem[BASE];
    issue(2'd0, ~prior);
    @(negedge clk);
    chk("wr_mem_we_high", {31'd0, mem_we}, 32'd1);
    rst_n = 1'b0;
    exp_q.delete();
    model_q.delete();
    last_data = 16'h0;
    #1;
    chk("wr_rst_mem_we_drop", {31'd0, mem_we}, 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    chk("wr_rst_mem_kept", {16'd0, mem[BASE]}, {16'd0, prior});
    chk("wr_rst_count", {16'd0, count}, 32'd0);

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      int r;
      r = $urandom_range(0, 9);
      if (r < 4)      issue(2'd0, 16'($urandom_range(0, 65535)));
      else if (r < 6) issue(2'd1, 16'h0);
      else if (r < 9) issue(2'd2, 16'h0);
      else            issue(2'd3, 16'h0);
    end
    wait_idle();
    chk("final_count", {16'd0, count}, 32'(model_q.size()));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule
